hub75_scan_driver: RTL and testbench
====================================

Name: hub75_scan_driver

Overview:
- Downstream consumer of the RGB565 graphics RAM.
- Walks the framebuffer through the RAM's registered read port and shifts pixel data into a HUB75 LED panel.
- Two half-panels (top and bottom) are driven in parallel; brightness uses binary-coded modulation (BCM) over PWM_BITS bit planes.
- Generates HUB75 shift clock, latch, output-enable and row address; owns all panel-facing timing.

Parameters:
WIDTH, 64, panel columns
HEIGHT, 32, panel rows (even; scan rows = HEIGHT/2)
PWM_BITS, 4, bit planes per channel, legal 1..5
BASE_TICKS, 8, display cycles of plane 0, >=1
(local) RAM_SIZE = WIDTH*HEIGHT; AW = $clog2(RAM_SIZE); RW = $clog2(HEIGHT/2)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  synchronous, active-low reset
enable  in  1  run scanning; sampled only at segment start
r_addr  out  AW  RAM read address
r_en  out  1  RAM read enable
r_data  in  16  RAM read data, RGB565; valid the cycle after r_en
r1,g1,b1  out  1 each  top-half colour bits
r2,g2,b2  out  1 each  bottom-half colour bits
hub_clk  out  1  panel shift clock
lat  out  1  panel latch
oe_n  out  1  panel output enable, active low
row_addr  out  RW  panel row select (A..E)
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- All outputs registered. Reset (rst_n=0 at posedge):
  - data bits, hub_clk, lat, r_en, r_addr, row_addr, frame_done = 0.
  - oe_n = 1.
  - FSM to IDLE; row=0, plane=0, column=0.
- Reset mid-operation aborts immediately; the next run restarts at row 0, plane 0.
- FSM: IDLE -> SHIFT -> LATCH -> DISPLAY -> (next segment: SHIFT, or IDLE).
- IDLE: oe_n=1. Enter SHIFT when enable=1.
- Segment = one (row, plane) pair. Order: planes 0..PWM_BITS-1 for row 0, then row 1, and so on up to row HEIGHT/2-1, then wrap to row 0.
- Segment timeline, cycle 0 = first SHIFT cycle:
  - oe_n=1 from cycle 0 through LATCH.
  - Column c output window: cycles 3+4c .. 6+4c.
  - During the window, r1/g1/b1/r2/g2/b2 hold column c values; hub_clk=1 only in window cycle 2 (7+4c-2 = 5+4c), 0 otherwise.
  - Reads are prefetched. Top address = row*WIDTH+c; bottom address = (row+HEIGHT/2)*WIDTH+c. Top read is issued before bottom read.
  - lat=1 for exactly one cycle at 3+4*WIDTH; row_addr updates to the segment row in the same cycle.
  - oe_n=0 for exactly BASE_TICKS<<plane cycles starting at 4+4*WIDTH.
  - Segment length = 4+4*WIDTH+(BASE_TICKS<<plane).
- Colour bit for plane p:
  - red = pix[11+(5-PWM_BITS)+p]
  - green = pix[5+(6-PWM_BITS)+p]
  - blue = pix[(5-PWM_BITS)+p]
  - Low bits below the selected window are ignored.
- Data outputs hold their last value outside column windows.
- enable=0 at a segment boundary -> IDLE (oe_n=1); resume from the next pending segment, not from row 0.
- frame_done=1 in the cycle after the final DISPLAY cycle of row HEIGHT/2-1, plane PWM_BITS-1.
- r_en=1 only in cycles where a read is issued; r_addr is never outside 0..RAM_SIZE-1.
- Plane counter and row counter wrap without overflow; the DISPLAY counter is sized for BASE_TICKS<<(PWM_BITS-1).

Decomposition:
- Package hub75_pkg:
  - FSM state enum (IDLE, SHIFT, LATCH, DISPLAY).
  - Column phase encoding (PH_TOP, PH_BOT, PH_DATA, PH_CLK).
  - Functions returning red/green/blue bit index for (PWM_BITS, p).
- Sub-module hub75_plane_timer: loadable down-counter. Loaded with BASE_TICKS<<plane, drives oe_n low while nonzero, pulses done on expiry.

Test Plan (WIDTH=4, HEIGHT=4, PWM_BITS=2, BASE_TICKS=2 unless noted):
- Reset then enable=1, RAM all 0xFFFF:
  - oe_n=1, lat=0 until cycle 19; lat pulse at cycle 19.
  - oe_n low cycles 20-21 (plane 0); next segment 24 long with oe_n low for 4 cycles.
  - frame_done at cycle 92; all six data bits 1 in every window.
- Address check:
  - Row 0 reads top 0..3, bottom 8..11; row 1 reads top 4..7, bottom 12..15.
  - row_addr changes 0->1 only on the lat cycle of the first row-1 segment.
- Colour mapping:
  - Top pixel 1 = 0xF800 -> r1=1 in column-1 window both planes.
  - 0x0800 -> r1=0 always.
  - 0x0400 -> g1=1 in plane 1 only.
  - 0x001F -> b1=1 both planes.
- Shift timing: per column exactly one hub_clk high cycle; data stable 2 cycles before and 1 cycle after it; 4 hub_clk pulses per segment.
- enable dropped mid-segment at cycle 10:
  - Segment completes (lat, DISPLAY), then IDLE with oe_n=1.
  - Re-enable resumes row 0 plane 1.
- rst_n=0 during DISPLAY:
  - Next cycle oe_n=1, row_addr=0, r_en=0.
  - After release, the first lat occurs at cycle 19 again.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan driver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hub75_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      LATCH   = 2'd2,
      DISPLAY = 2'd3
   } state_e;

   // Position inside the 4-cycle column slot, taken from the low bits of the
   // shift cycle counter (the cycle in which the effect is visible on the pins):
   //   PH_TOP  : top-half read on the RAM bus
   //   PH_BOT  : bottom-half read on the RAM bus; shift clock high for the column on display
   //   PH_DATA : both words available, colour bits load at the end of this cycle
   //   PH_CLK  : new colour bits on the pins, set-up cycle ahead of the shift clock
   typedef enum logic [1:0] {
      PH_TOP  = 2'd0,
      PH_BOT  = 2'd1,
      PH_DATA = 2'd2,
      PH_CLK  = 2'd3
   } phase_e;

   // RGB565 bit index used for bit plane p; only the top pwm_bits of each
   // channel are displayed.
   function automatic int red_idx(input int pwm_bits, input int p);
      return 11 + (5 - pwm_bits) + p;
   endfunction

   function automatic int green_idx(input int pwm_bits, input int p);
      return 5 + (6 - pwm_bits) + p;
   endfunction

   function automatic int blue_idx(input int pwm_bits, input int p);
      return (5 - pwm_bits) + p;
   endfunction

endpackage

// File: rtl/hub75_scan_driver_if.sv
// Registered-read RAM port between the scan driver (master) and the graphics RAM (slave).
// Latency: r_data is valid the cycle after r_en.
// Backpressure: none; the RAM must answer every read.
interface hub75_scan_driver_if #(
   parameter int AW = 11
);
   logic [AW-1:0] r_addr;
   logic          r_en;
   logic [15:0]   r_data;

   modport master (output r_addr, output r_en, input r_data);
   modport slave  (input r_addr, input r_en, output r_data);
endinterface

// File: rtl/hub75_plane_timer.sv
// Display-period down-counter: loaded with the plane's tick count, holds oe_n low while running.
// Latency: oe_n falls the cycle after load and stays low for exactly load_val cycles.
// Backpressure: none. Ports: load/load_val start a period, oe_n (registered), done = last low cycle.
module hub75_plane_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          oe_n,
   output logic          done
);

   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_nx;

   always_comb begin
      cnt_nx = cnt;
      if (load) begin
         cnt_nx = load_val;
      end else if (cnt != '0) begin
         cnt_nx = cnt - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         oe_n <= 1'b1;
      end else begin
         cnt  <= cnt_nx;
         oe_n <= (cnt_nx == '0);
      end
   end

   // Count of one means this is the final lit cycle.
   assign done = (cnt == TW'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 panel scanner: fetches RGB565 pixels over a registered-read RAM port and shifts two
// half-panels in parallel with BCM brightness. Latency: segment = 4+4*WIDTH+(BASE_TICKS<<plane)
// cycles; all outputs registered. Backpressure: none; enable only sampled at segment start.
// Ports: clk, rst_n (sync, active low), enable, ram (RAM read master), r1/g1/b1 + r2/g2/b2
// colour bits, hub_clk, lat, oe_n, row_addr, frame_done.
module hub75_scan_driver
   import hub75_pkg::*;
#(
   parameter  int WIDTH      = 64,
   parameter  int HEIGHT     = 32,
   parameter  int PWM_BITS   = 4,
   parameter  int BASE_TICKS = 8,
   localparam int RAM_SIZE   = WIDTH * HEIGHT,
   localparam int AW         = $clog2(RAM_SIZE),
   localparam int RW         = $clog2(HEIGHT / 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   hub75_scan_driver_if.master ram,
   output logic                r1,
   output logic                g1,
   output logic                b1,
   output logic                r2,
   output logic                g2,
   output logic                b2,
   output logic                hub_clk,
   output logic                lat,
   output logic                oe_n,
   output logic [RW-1:0]       row_addr,
   output logic                frame_done
);

   localparam int SCAN       = HEIGHT / 2;
   localparam int SHIFT_LAST = 4 * WIDTH + 2;
   localparam int CW         = $clog2(4 * WIDTH + 3);
   localparam int PW         = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
   localparam int TW         = $clog2((BASE_TICKS << (PWM_BITS - 1)) + 1);

   state_e          state, state_nx;
   logic [CW-1:0]   cyc, cyc_nx;
   logic [RW-1:0]   row, row_nx;
   logic [PW-1:0]   plane, plane_nx;

   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_done;
   logic            last_plane, last_row;

   phase_e          ph_nx, cur_ph;
   logic            rd_nx;
   logic [AW-1:0]   rd_addr_nx;
   logic [AW-1:0]   row_base;
   logic            shifting;
   logic [3:0]      ri, gi, bi;

   logic [15:0]     top_q;
   logic            r_en_q;
   logic [AW-1:0]   r_addr_q;

   assign last_plane = (plane == PW'(PWM_BITS - 1));
   assign last_row   = (row == RW'(SCAN - 1));
   assign tmr_val    = TW'(BASE_TICKS) << plane;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cyc   <= '0;
         row   <= '0;
         plane <= '0;
      end else begin
         state <= state_nx;
         cyc   <= cyc_nx;
         row   <= row_nx;
         plane <= plane_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cyc_nx   = cyc;
      row_nx   = row;
      plane_nx = plane;
      tmr_load = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nx = SHIFT;
               cyc_nx   = '0;
            end
         end
         SHIFT: begin
            if (cyc == CW'(SHIFT_LAST)) begin
               state_nx = LATCH;
            end else begin
               cyc_nx = cyc + CW'(1);
            end
         end
         LATCH: begin
            state_nx = DISPLAY;
            tmr_load = 1'b1;
         end
         DISPLAY: begin
            if (tmr_done) begin
               // Segment finished: advance plane, then row, and decide run/stop.
               if (last_plane) begin
                  plane_nx = '0;
                  row_nx   = last_row ? '0 : row + RW'(1);
               end else begin
                  plane_nx = plane + PW'(1);
               end
               cyc_nx   = '0;
               state_nx = enable ? SHIFT : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- read address / decode ----------------
   // Pin-facing registers are computed from next-cycle state so that their
   // value lines up with the segment cycle they belong to.
   always_comb begin
      ph_nx      = phase_e'(cyc_nx[1:0]);
      rd_nx      = (state_nx == SHIFT) && (cyc_nx < CW'(4 * WIDTH)) &&
                   ((ph_nx == PH_TOP) || (ph_nx == PH_BOT));
      row_base   = AW'(row_nx) + ((ph_nx == PH_BOT) ? AW'(SCAN) : '0);
      rd_addr_nx = row_base * AW'(WIDTH) + AW'(cyc_nx[CW-1:2]);
   end

   always_comb begin
      cur_ph   = phase_e'(cyc[1:0]);
      shifting = (state == SHIFT) && (cyc < CW'(4 * WIDTH));
      ri       = 4'(red_idx(PWM_BITS, int'(plane)));
      gi       = 4'(green_idx(PWM_BITS, int'(plane)));
      bi       = 4'(blue_idx(PWM_BITS, int'(plane)));
   end

   // ---------------- output registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en_q     <= 1'b0;
         r_addr_q   <= '0;
         hub_clk    <= 1'b0;
         lat        <= 1'b0;
         row_addr   <= '0;
         frame_done <= 1'b0;
         top_q      <= '0;
         {r1, g1, b1, r2, g2, b2} <= 6'b0;
      end else begin
         r_en_q <= rd_nx;
         if (rd_nx) begin
            r_addr_q <= rd_addr_nx;
         end
         // Column 0 has no clock in its first slot; the pulse trails the data by two cycles.
         hub_clk    <= (state_nx == SHIFT) && (ph_nx == PH_BOT) && (cyc_nx >= CW'(5));
         lat        <= (state_nx == LATCH);
         if (state_nx == LATCH) begin
            row_addr <= row;
         end
         frame_done <= (state == DISPLAY) && tmr_done && last_plane && last_row;
         // Top word arrives one cycle before the bottom word; park it.
         if (shifting && (cur_ph == PH_BOT)) begin
            top_q <= ram.r_data;
         end
         if (shifting && (cur_ph == PH_DATA)) begin
            {r1, g1, b1} <= {top_q[ri], top_q[gi], top_q[bi]};
            {r2, g2, b2} <= {ram.r_data[ri], ram.r_data[gi], ram.r_data[bi]};
         end
      end
   end

   assign ram.r_en   = r_en_q;
   assign ram.r_addr = r_addr_q;

   hub75_plane_timer #(
      .TW(TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .oe_n     (oe_n),
      .done     (tmr_done)
   );

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: per-cycle behavioural model plus directed literal checks.
module tb_hub75_scan_driver;
   localparam int W = 4, H = 4, P = 2, B = 2, SCAN = H / 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic r1, g1, b1, r2, g2, b2, hub_clk, lat, oe_n, frame_done;
   logic [0:0] row_addr;
   logic [15:0] mem [16];

   int vectors = 0;
   int miscompares = 0;
   int nprint = 0;

   hub75_scan_driver_if #(.AW(4)) ram_if ();

   hub75_scan_driver #(
      .WIDTH(W), .HEIGHT(H), .PWM_BITS(P), .BASE_TICKS(B)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ram(ram_if),
      .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
      .hub_clk(hub_clk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Graphics RAM with registered read port.
   always @(posedge clk) if (ram_if.r_en) ram_if.r_data <= mem[ram_if.r_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_valid = 0, m_idle = 1, e_fd = 0;
   int m_k = 0, m_row = 0, m_plane = 0;
   logic [5:0] e_dat;
   logic [3:0] e_raddr;
   logic [0:0] e_rowaddr;

   function automatic int seglen(input int p);
      return 4 + 4 * W + (B << p);
   endfunction

   function automatic logic [2:0] rgb(input logic [15:0] px, input int p);
      return {px[11 + (5 - P) + p], px[5 + (6 - P) + p], px[(5 - P) + p]};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1; m_idle = 1; m_k = 0; m_row = 0; m_plane = 0;
         e_fd = 0; e_dat = '0; e_raddr = '0; e_rowaddr = '0;
      end else if (m_valid) begin
         e_fd = 0;
         if (m_idle) begin
            if (enable) begin m_idle = 0; m_k = 0; end
         end else if (m_k == seglen(m_plane) - 1) begin
            if (m_row == SCAN - 1 && m_plane == P - 1) e_fd = 1;
            m_plane++;
            if (m_plane == P) begin m_plane = 0; m_row = (m_row + 1) % SCAN; end
            if (enable) m_k = 0; else m_idle = 1;
         end else begin
            m_k++;
         end
         if (!m_idle) begin
            if (m_k < 4 * W && m_k % 4 < 2)
               e_raddr = 4'(((m_k % 4 == 0) ? m_row : m_row + SCAN) * W + m_k / 4);
            if (m_k >= 3 && m_k < 3 + 4 * W && (m_k - 3) % 4 == 0)
               e_dat = {rgb(mem[m_row * W + (m_k - 3) / 4], m_plane),
                        rgb(mem[(m_row + SCAN) * W + (m_k - 3) / 4], m_plane)};
            if (m_k == 3 + 4 * W) e_rowaddr = 1'(m_row);
         end
      end
   end

   // Compare every cycle against the model.
   always @(negedge clk) begin
      logic [15:0] got, exp;
      bit s;
      int k;
      if (m_valid) begin
         s = !m_idle;
         k = m_k;
         exp = {e_dat,
                1'(s && k >= 5 && k <= 4 * W + 1 && (k - 5) % 4 == 0),
                1'(s && k == 3 + 4 * W),
                1'(!(s && k >= 4 + 4 * W && k < 4 + 4 * W + (B << m_plane))),
                1'(s && k < 4 * W && k % 4 < 2),
                e_raddr, e_rowaddr, 1'(e_fd)};
         got = {r1, g1, b1, r2, g2, b2, hub_clk, lat, oe_n, ram_if.r_en,
                ram_if.r_addr, row_addr, frame_done};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            if (nprint < 20) $display("FAIL model t=%0t: got %h expected %h", $time, got, exp);
            nprint++;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int first_lat, first_fd, oe0, oe1, hubs, ones, cnt, ren_late;
      logic [31:0] a0, a1;
      logic [11:0] col0, col1;
      logic [0:0] ra64, ra65;

      for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
      repeat (3) @(negedge clk);
      check("reset_state",
            {16'h0, oe_n, lat, ram_if.r_en, hub_clk, frame_done, row_addr, ram_if.r_addr,
             r1, g1, b1, r2, g2, b2}, 32'h8000);

      // All-white frame timing and address order.
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      first_lat = -1; first_fd = -1; oe0 = 0; oe1 = 0; hubs = 0; ones = 1;
      a0 = '0; a1 = '0; ra64 = '0; ra65 = '0;
      for (int c = 0; c < 96; c++) begin
         @(negedge clk);
         if (lat && first_lat < 0) first_lat = c;
         if (frame_done && first_fd < 0) first_fd = c;
         if (c < 22 && !oe_n) oe0++;
         if (c >= 22 && c < 46 && !oe_n) oe1++;
         if (c < 22 && hub_clk) hubs++;
         if (c >= 3 && c < 19 && {r1, g1, b1, r2, g2, b2} != 6'h3F) ones = 0;
         if (c < 22 && ram_if.r_en) a0 = {a0[27:0], ram_if.r_addr};
         if (c >= 46 && c < 68 && ram_if.r_en) a1 = {a1[27:0], ram_if.r_addr};
         if (c == 64) ra64 = row_addr;
         if (c == 65) ra65 = row_addr;
      end
      check("first_lat_cycle", first_lat, 19);
      check("frame_done_cycle", first_fd, 92);
      check("oe_low_plane0", oe0, 2);
      check("oe_low_plane1", oe1, 4);
      check("hub_clk_pulses", hubs, 4);
      check("white_data_bits", ones, 1);
      check("row0_addresses", a0, 32'h08192A3B);
      check("row1_addresses", a1, 32'h4C5D6E7F);
      check("row_addr_before_lat", ra64, 0);
      check("row_addr_on_lat", ra65, 1);

      // Colour mapping on top row 0.
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0800; mem[1] = 16'hF800; mem[2] = 16'h0400; mem[3] = 16'h001F;
      do_reset();
      enable = 1'b1;
      col0 = '0; col1 = '0;
      for (int c = 0; c < 46; c++) begin
         @(negedge clk);
         if (c < 20 && c >= 4 && (c - 4) % 4 == 0) col0 = {col0[8:0], r1, g1, b1};
         if (c >= 26 && c < 42 && (c - 26) % 4 == 0) col1 = {col1[8:0], r1, g1, b1};
      end
      check("colour_plane0", col0, 12'h101);
      check("colour_plane1", col1, 12'h111);

      // Enable dropped mid-segment, then resume.
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      do_reset();
      enable = 1'b1;
      cnt = 0; oe0 = 0; ren_late = 0;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (lat) cnt++;
         if (!oe_n) oe0++;
         if (c >= 22 && ram_if.r_en) ren_late++;
         if (c == 10) enable = 1'b0;
      end
      check("drop_lat_count", cnt, 1);
      check("drop_oe_low", oe0, 2);
      check("drop_idle_no_reads", ren_late, 0);
      enable = 1'b1;
      first_lat = -1; oe1 = 0;
      for (int d = 0; d < 24; d++) begin
         @(negedge clk);
         if (lat && first_lat < 0) first_lat = d;
         if (!oe_n) oe1++;
      end
      check("resume_lat_cycle", first_lat, 19);
      check("resume_plane1_oe", oe1, 4);

      // Reset during a row-1 display period.
      do_reset();
      enable = 1'b1;
      for (int c = 0; c <= 66; c++) @(negedge clk);
      check("row1_display", {oe_n, row_addr}, 2'b01);
      rst_n = 1'b0;
      @(negedge clk);
      check("after_reset", {oe_n, row_addr, ram_if.r_en, lat}, 4'b1000);
      rst_n = 1'b1;
      first_lat = -1;
      for (int d = 0; d < 25; d++) begin
         @(negedge clk);
         if (lat && first_lat < 0) first_lat = d;
      end
      check("lat_after_reset", first_lat, 19);

      // Random contents, random enable gaps and resets.
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
         if (enable) begin
            if ($urandom_range(0, 79) == 0) enable = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            enable = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
